// File: rtl/sound_pkg.sv
// Shared constants and types for the DOC5503 sound-RAM wave fetch path.
package sound_pkg;

    localparam logic [20:0] SOUND_RAM_WORD_BASE = 21'h10000;
    localparam logic [7:0]  SILENCE_BYTE        = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrain
    } fetch_state_e;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] offset);
        return word[8*offset +: 8];
    endfunction

endpackage

// File: rtl/sound_wave_cache.sv
// Direct-mapped cache of 32-bit sound-RAM words, addressed by word address (byte addr >> 2).
module sound_wave_cache
    import sound_pkg::*;
#(
    parameter int unsigned CACHE_LINES = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [13:0] lookup_word_i,
    output logic        lookup_hit_o,
    output logic [31:0] lookup_data_o,
    input  logic        fill_i,
    input  logic        fill_valid_i,
    input  logic [13:0] fill_word_i,
    input  logic [31:0] fill_data_i,
    input  logic        snoop_i,
    input  logic [13:0] snoop_word_i
);

    localparam int unsigned IW   = $clog2(CACHE_LINES);
    localparam int unsigned IdxW = (IW > 0) ? IW : 1;
    localparam int unsigned TagW = 14 - IW;
    localparam logic [13:0] IdxMask = 14'(CACHE_LINES - 1);

    logic [TagW-1:0]        tag_q [CACHE_LINES];
    logic [31:0]            data_q[CACHE_LINES];
    logic [CACHE_LINES-1:0] valid_q;

    logic [IdxW-1:0] l_idx, f_idx, s_idx;
    logic [TagW-1:0] l_tag, f_tag, s_tag;

    assign l_idx = IdxW'(lookup_word_i & IdxMask);
    assign f_idx = IdxW'(fill_word_i & IdxMask);
    assign s_idx = IdxW'(snoop_word_i & IdxMask);
    assign l_tag = TagW'(lookup_word_i >> IW);
    assign f_tag = TagW'(fill_word_i >> IW);
    assign s_tag = TagW'(snoop_word_i >> IW);

    // Lookup reads the arrays as they stand, so a same-cycle snoop still sees the old word.
    assign lookup_hit_o  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign lookup_data_o = data_q[l_idx];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else begin
            if (snoop_i && (tag_q[s_idx] == s_tag)) begin
                valid_q[s_idx] <= 1'b0;
            end
            // Fill wins over a snoop of the old line; the caller folds a same-word snoop into fill_valid_i.
            if (fill_i) begin
                valid_q[f_idx] <= fill_valid_i;
                tag_q[f_idx]   <= f_tag;
                data_q[f_idx]  <= fill_data_i;
            end
        end
    end

endmodule

// File: rtl/sound_wave_fetch.sv
// DOC byte reads -> SDRAM word fetches with a small snooped word cache and fetch timeout.
module sound_wave_fetch
    import sound_pkg::*;
#(
    parameter int unsigned CACHE_LINES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        wave_rd_i,
    input  logic [15:0] wave_addr_i,
    output logic [7:0]  wave_data_o,
    output logic        wave_data_ready_o,
    output logic        mem_rd_o,
    output logic [20:0] mem_addr_o,
    input  logic [31:0] mem_q_i,
    input  logic        mem_ready_i,
    input  logic        snoop_wr_i,
    input  logic [15:0] snoop_addr_i,
    output logic        err_overflow_o,
    output logic        err_timeout_o
);

    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    fetch_state_e    state_q, state_d;
    logic            pend_q, pend_d;
    logic [15:0]     pend_addr_q, pend_addr_d;
    logic [15:0]     req_addr_q, req_addr_d;
    logic            poison_q, poison_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            mem_rd_q, mem_rd_d;
    logic [20:0]     mem_addr_q, mem_addr_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_to_q, err_to_d;

    logic        serve_pend, serve_new;
    logic [15:0] cur_addr;
    logic        hit;
    logic [31:0] hit_line;
    logic        fill_en, fill_valid;
    logic        snoop_req_hit;
    logic        unused_snoop_bits;

    assign unused_snoop_bits = ^snoop_addr_i[1:0];

    // The pending slot always goes first; a fresh read waits out a ready cycle in the slot.
    assign serve_pend = (state_q == StIdle) && pend_q;
    assign serve_new  = (state_q == StIdle) && !pend_q && wave_rd_i && !ready_q;
    assign cur_addr   = pend_q ? pend_addr_q : wave_addr_i;

    assign snoop_req_hit = snoop_wr_i && (snoop_addr_i[15:2] == req_addr_q[15:2]);
    assign fill_valid    = !(poison_q || snoop_req_hit);

    sound_wave_cache #(
        .CACHE_LINES (CACHE_LINES)
    ) u_cache (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .lookup_word_i (cur_addr[15:2]),
        .lookup_hit_o  (hit),
        .lookup_data_o (hit_line),
        .fill_i        (fill_en),
        .fill_valid_i  (fill_valid),
        .fill_word_i   (req_addr_q[15:2]),
        .fill_data_i   (mem_q_i),
        .snoop_i       (snoop_wr_i),
        .snoop_word_i  (snoop_addr_i[15:2])
    );

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        req_addr_d  = req_addr_q;
        poison_d    = poison_q || snoop_req_hit;
        cnt_d       = cnt_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        err_ovf_d   = err_ovf_q;
        err_to_d    = err_to_q;
        fill_en     = 1'b0;

        if (serve_pend) begin
            pend_d = 1'b0;
        end
        if (wave_rd_i && !serve_new) begin
            if (!pend_q || serve_pend) begin
                pend_d      = 1'b1;
                pend_addr_d = wave_addr_i;
            end else begin
                err_ovf_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (serve_pend || serve_new) begin
                    if (!enable_i) begin
                        ready_d = 1'b1;
                        data_d  = SILENCE_BYTE;
                    end else if (hit) begin
                        ready_d = 1'b1;
                        data_d  = byte_sel(hit_line, cur_addr[1:0]);
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = SOUND_RAM_WORD_BASE | {7'd0, cur_addr[15:2]};
                        req_addr_d = cur_addr;
                        cnt_d      = '0;
                        poison_d   = snoop_wr_i && (snoop_addr_i[15:2] == cur_addr[15:2]);
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_ready_i) begin
                    fill_en = 1'b1;
                    ready_d = 1'b1;
                    data_d  = byte_sel(mem_q_i, req_addr_q[1:0]);
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    ready_d  = 1'b1;
                    data_d   = SILENCE_BYTE;
                    err_to_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StDrain;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                // The abandoned fetch may still answer; swallow it without filling.
                if (mem_ready_i || (cnt_q == CntLast)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            req_addr_q  <= '0;
            poison_q    <= 1'b0;
            cnt_q       <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            req_addr_q  <= req_addr_d;
            poison_q    <= poison_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            err_ovf_q   <= err_ovf_d;
            err_to_q    <= err_to_d;
        end
    end

    assign wave_data_o       = data_q;
    assign wave_data_ready_o = ready_q;
    assign mem_rd_o          = mem_rd_q;
    assign mem_addr_o        = mem_addr_q;
    assign err_overflow_o    = err_ovf_q;
    assign err_timeout_o     = err_to_q;

endmodule

// File: tb/tb_sound_wave_fetch.sv
// Scenario bench for sound_wave_fetch: returned bytes are checked against a queue of expectations.
module tb_sound_wave_fetch;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        wave_rd_i;
    logic [15:0] wave_addr_i;
    logic [7:0]  wave_data_o;
    logic        wave_data_ready_o;
    logic        mem_rd_o;
    logic [20:0] mem_addr_o;
    logic [31:0] mem_q_i;
    logic        mem_ready_i;
    logic        snoop_wr_i;
    logic [15:0] snoop_addr_i;
    logic        err_overflow_o;
    logic        err_timeout_o;

    int         vectors     = 0;
    int         miscompares = 0;
    int         ready_cnt   = 0;
    int         mem_rd_cnt  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    sound_wave_fetch #(
        .CACHE_LINES    (4),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .enable_i          (enable_i),
        .wave_rd_i         (wave_rd_i),
        .wave_addr_i       (wave_addr_i),
        .wave_data_o       (wave_data_o),
        .wave_data_ready_o (wave_data_ready_o),
        .mem_rd_o          (mem_rd_o),
        .mem_addr_o        (mem_addr_o),
        .mem_q_i           (mem_q_i),
        .mem_ready_i       (mem_ready_i),
        .snoop_wr_i        (snoop_wr_i),
        .snoop_addr_i      (snoop_addr_i),
        .err_overflow_o    (err_overflow_o),
        .err_timeout_o     (err_timeout_o)
    );

    // Scoreboard: every ready pulse pops the oldest expected byte.
    always @(negedge clk) begin
        if (mem_rd_o) mem_rd_cnt++;
        if (wave_data_ready_o) begin
            ready_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_ready: got data %h, required no ready pulse", wave_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wave_data_o !== mon_exp) begin
                    miscompares++;
                    $display("FAIL wave_data: got %h, required %h", wave_data_o, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rd(input logic [15:0] a);
        wave_rd_i   = 1'b1;
        wave_addr_i = a;
        tick();
        wave_rd_i = 1'b0;
    endtask

    task automatic give_mem(input logic [31:0] q);
        mem_ready_i = 1'b1;
        mem_q_i     = q;
        tick();
        mem_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; enable_i = 1'b1; wave_rd_i = 1'b0; wave_addr_i = '0;
        mem_q_i = '0; mem_ready_i = 1'b0; snoop_wr_i = 1'b0; snoop_addr_i = '0;
        tick(3);
        vectors++;
        if (wave_data_o !== 8'h00 || wave_data_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%b, required 00/0", wave_data_o, wave_data_ready_o);
        end
        vectors++;
        if (mem_rd_o !== 1'b0 || mem_addr_o !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_mem: got %b/%h, required 0/000000", mem_rd_o, mem_addr_o);
        end
        vectors++;
        if (err_overflow_o !== 1'b0 || err_timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b%b, required 00", err_overflow_o, err_timeout_o);
        end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_cold_read();
        exp_q.push_back(8'hBB);
        pulse_rd(16'h1235);
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h1048D) begin
            miscompares++;
            $display("FAIL cold_fetch: got rd=%b addr=%h, required rd=1 addr=1048d", mem_rd_o, mem_addr_o);
        end
        tick();
        vectors++;
        if (mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_rd_pulse_width: got %b, required 0", mem_rd_o);
        end
        tick(3);
        give_mem(32'hDDCCBBAA);
        vectors++;
        if (wave_data_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL cold_ready_latency: got %b, required 1", wave_data_ready_o);
        end
        tick();
    endtask

    task automatic test_hit();
        exp_q.push_back(8'hCC);
        pulse_rd(16'h1236);
        vectors++;
        if (mem_rd_o !== 1'b0 || wave_data_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL hit: got rd=%b ready=%b, required rd=0 ready=1", mem_rd_o, wave_data_ready_o);
        end
        tick();
    endtask

    task automatic test_snoop();
        snoop_wr_i = 1'b1; snoop_addr_i = 16'h1234;
        tick();
        snoop_wr_i = 1'b0;
        exp_q.push_back(8'h11);
        pulse_rd(16'h1234);
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h1048D) begin
            miscompares++;
            $display("FAIL snoop_refetch: got rd=%b addr=%h, required rd=1 addr=1048d", mem_rd_o, mem_addr_o);
        end
        tick(2);
        give_mem(32'h44332211);
        tick();
        // Hit and snoop to the same word in one cycle: old byte out, line gone after.
        exp_q.push_back(8'h11);
        snoop_wr_i = 1'b1; snoop_addr_i = 16'h1236;
        pulse_rd(16'h1234);
        snoop_wr_i = 1'b0;
        vectors++;
        if (mem_rd_o !== 1'b0 || wave_data_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL snoop_same_cycle_hit: got rd=%b ready=%b, required rd=0 ready=1", mem_rd_o, wave_data_ready_o);
        end
        tick();
        exp_q.push_back(8'h55);
        pulse_rd(16'h1235);
        vectors++;
        if (mem_rd_o !== 1'b1) begin
            miscompares++;
            $display("FAIL snoop_after_hit_miss: got rd=%b, required 1", mem_rd_o);
        end
        give_mem(32'h00005500);
        tick();
    endtask

    task automatic test_poison();
        exp_q.push_back(8'hD3);
        pulse_rd(16'h2000);
        tick();
        snoop_wr_i = 1'b1; snoop_addr_i = 16'h2002;
        tick();
        snoop_wr_i = 1'b0;
        give_mem(32'hA0B1C2D3);
        vectors++;
        if (wave_data_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL poison_ready: got %b, required 1", wave_data_ready_o);
        end
        tick();
        exp_q.push_back(8'hC2);
        pulse_rd(16'h2001);
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h10800) begin
            miscompares++;
            $display("FAIL poison_line_invalid: got rd=%b addr=%h, required rd=1 addr=010800", mem_rd_o, mem_addr_o);
        end
        give_mem(32'hA0B1C2D3);
        tick();
    endtask

    task automatic test_disabled();
        enable_i = 1'b0;
        exp_q.push_back(8'h80);
        pulse_rd(16'h1235);
        vectors++;
        if (mem_rd_o !== 1'b0 || wave_data_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL disabled_cached: got rd=%b ready=%b, required rd=0 ready=1", mem_rd_o, wave_data_ready_o);
        end
        tick();
        exp_q.push_back(8'h80);
        pulse_rd(16'hABCD);
        vectors++;
        if (mem_rd_o !== 1'b0 || wave_data_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL disabled_uncached: got rd=%b ready=%b, required rd=0 ready=1", mem_rd_o, wave_data_ready_o);
        end
        tick();
        enable_i = 1'b1;
    endtask

    task automatic test_timeout();
        int n;
        exp_q.push_back(8'h80);
        pulse_rd(16'h3000);
        n = 0;
        while (wave_data_ready_o !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 255) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles, required 255", n);
        end
        vectors++;
        if (err_timeout_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_err: got %b, required 1", err_timeout_o);
        end
        tick(44);
        give_mem(32'hFFFFFFFF);
        vectors++;
        if (wave_data_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL late_ready_discard: got ready=%b, required 0", wave_data_ready_o);
        end
        tick(2);
        exp_q.push_back(8'h57);
        pulse_rd(16'h3000);
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h10C00) begin
            miscompares++;
            $display("FAIL post_timeout_fetch: got rd=%b addr=%h, required rd=1 addr=010c00", mem_rd_o, mem_addr_o);
        end
        give_mem(32'h00000057);
        tick();
    endtask

    task automatic test_back_to_back();
        int r0;
        int m0;
        r0 = ready_cnt;
        m0 = mem_rd_cnt;
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        pulse_rd(16'h4000);
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h11000) begin
            miscompares++;
            $display("FAIL b2b_first_fetch: got rd=%b addr=%h, required rd=1 addr=011000", mem_rd_o, mem_addr_o);
        end
        vectors++;
        if (err_overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_early: got %b, required 0", err_overflow_o);
        end
        pulse_rd(16'h5004);
        pulse_rd(16'h6008);
        vectors++;
        if (err_overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b, required 1", err_overflow_o);
        end
        tick();
        give_mem(32'h000000E1);
        tick();
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 21'h11401) begin
            miscompares++;
            $display("FAIL b2b_queued_fetch: got rd=%b addr=%h, required rd=1 addr=011401", mem_rd_o, mem_addr_o);
        end
        tick();
        give_mem(32'h000000E2);
        tick(4);
        vectors++;
        if (ready_cnt - r0 != 2 || mem_rd_cnt - m0 != 2) begin
            miscompares++;
            $display("FAIL b2b_counts: got ready=%0d fetch=%0d, required 2 and 2", ready_cnt - r0, mem_rd_cnt - m0);
        end
    endtask

    task automatic test_reset_mid_wait();
        pulse_rd(16'h7000);
        tick(2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        give_mem(32'h12345678);
        vectors++;
        if (wave_data_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abandon: got ready=%b, required 0", wave_data_ready_o);
        end
        vectors++;
        if (err_overflow_o !== 1'b0 || err_timeout_o !== 1'b0 || mem_addr_o !== 21'h0) begin
            miscompares++;
            $display("FAIL reset_clear: got ovf=%b to=%b addr=%h, required 0 0 000000",
                     err_overflow_o, err_timeout_o, mem_addr_o);
        end
        tick();
        exp_q.push_back(8'hCC);
        pulse_rd(16'h1236);
        vectors++;
        if (mem_rd_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_invalidates: got rd=%b, required 1", mem_rd_o);
        end
        give_mem(32'hDDCCBBAA);
        tick(2);
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_hit();
        test_snoop();
        test_poison();
        test_disabled();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_responses: got %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
